// File: rtl/display_scan_mux.sv
// display_scan_mux: time-multiplexes four BCD digits onto one 7-segment decoder with
// anode guard blanking, frame-synchronous shadow registers, leading-zero suppression and blink.
module display_scan_mux #(
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 16,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic [3:0] hourTens,
  input  logic [3:0] hourOnes,
  input  logic [3:0] minTens,
  input  logic [3:0] minOnes,
  input  logic [3:0] blinkMask,
  input  logic       suppressLeadingZero,
  output logic [3:0] numberToDecode,
  output logic [3:0] anodeN,
  output logic       frameStart,
  output logic       blinkPhase
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] slot_q, slot_d;
  logic [FW-1:0] frame_q, frame_d;
  logic [3:0][3:0] dig_q, dig_d;
  logic [3:0] mask_q, mask_d, cur;
  logic show_zero_q, show_zero_d, blink_q, blink_d, fs_q, fs_d;
  logic slot_end, frame_end, blank;
  // Suppression is held inverted so the all-zero reset frame shows hourTens suppressed.
  always_comb begin
    slot_end    = cnt_q == CW'(SCAN_DIV - 1);
    frame_end   = slot_end && slot_q == 2'd3;
    cnt_d       = slot_end ? '0 : cnt_q + CW'(1);
    slot_d      = slot_end ? slot_q + 2'd1 : slot_q;
    frame_d     = !frame_end ? frame_q : frame_q == FW'(BLINK_FRAMES - 1) ? '0 : frame_q + FW'(1);
    blink_d     = blink_q ^ (frame_end && frame_q == FW'(BLINK_FRAMES - 1));
    dig_d       = frame_end ? {hourTens, hourOnes, minTens, minOnes} : dig_q;
    mask_d      = frame_end ? blinkMask : mask_q;
    show_zero_d = frame_end ? ~suppressLeadingZero : show_zero_q;
    fs_d        = frame_end;
    cur         = dig_q[~slot_q];
    blank       = (mask_q[~slot_q] & blink_q) | (slot_q == 2'd0 && !show_zero_q && cur == 4'd0);
    numberToDecode = cur;
    anodeN      = (cnt_q < CW'(BLANK_CYCLES) || blank) ? 4'hF : ~(4'b0001 << ~slot_q);
    frameStart  = fs_q;
    blinkPhase  = blink_q;
  end
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cnt_q       <= '0;
      slot_q      <= '0;
      frame_q     <= '0;
      dig_q       <= '0;
      mask_q      <= '0;
      show_zero_q <= 1'b0;
      blink_q     <= 1'b0;
      fs_q        <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      slot_q      <= slot_d;
      frame_q     <= frame_d;
      dig_q       <= dig_d;
      mask_q      <= mask_d;
      show_zero_q <= show_zero_d;
      blink_q     <= blink_d;
      fs_q        <= fs_d;
    end
  end
endmodule

// File: tb/tb_display_scan_mux.sv
// tb_display_scan_mux: randomized and directed checks of display_scan_mux against a
// cycle-index reference model (slot, phase and shadow contents derived from elapsed cycles).
module tb_display_scan_mux;
  localparam int SD = 8, BC = 2, BF = 2, FRAME = 4 * SD;
  logic clk = 1'b0, resetN = 1'b1, slz = 1'b0;
  logic [3:0] ht = '0, ho = '0, mt = '0, mo = '0, bm = '0;
  logic [3:0] num, an;
  logic fs, bp;
  int t = 0, checks = 0, passes = 0;
  logic [3:0] sh[4];
  logic [3:0] sh_mask;
  logic sh_sup;

  display_scan_mux #(.SCAN_DIV(SD), .BLANK_CYCLES(BC), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .resetN(resetN), .hourTens(ht), .hourOnes(ho), .minTens(mt), .minOnes(mo),
    .blinkMask(bm), .suppressLeadingZero(slz), .numberToDecode(num), .anodeN(an),
    .frameStart(fs), .blinkPhase(bp)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] model();
    int f, s, c;
    logic ph, blank, fst;
    logic [3:0] d, a;
    f = t / FRAME;
    s = (t / SD) % 4;
    c = t % SD;
    ph = ((f / BF) % 2) == 1;
    d = sh[s];
    blank = (sh_mask[3 - s] && ph) || (s == 0 && sh_sup && d == 4'd0);
    a = (c < BC || blank) ? 4'hF : ~(4'b1000 >> s);
    fst = (t % FRAME == 0) && t > 0;
    return {d, a, fst, ph};
  endfunction

  task automatic model_reset();
    t = 0;
    for (int i = 0; i < 4; i++) sh[i] = '0;
    sh_mask = '0;
    sh_sup = 1'b1;
  endtask

  task automatic tick();
    if (t % FRAME == FRAME - 1) begin
      sh[0] = ht; sh[1] = ho; sh[2] = mt; sh[3] = mo;
      sh_mask = bm;
      sh_sup = slz;
    end
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic test_reset();
    #1 resetN = 1'b0;
    #2;
    checks++;
    if ({num, an, fs, bp} !== 10'b0000_1111_0_0)
      $display("FAIL reset_async got %h want %h", {num, an, fs, bp}, 10'b0000_1111_0_0);
    else passes++;
    ht = 4'd9; mo = 4'd5;
    @(negedge clk); @(negedge clk);
    resetN = 1'b1;
    model_reset();
    #1;
    for (int k = 0; k < FRAME + 4; k++) begin
      checks++;
      if ({num, an, fs, bp} !== model())
        $display("FAIL reset_frame t=%0d got %h want %h", t, {num, an, fs, bp}, model());
      else passes++;
      tick();
    end
  endtask

  task automatic test_digits();
    ht = 4'd1; ho = 4'd2; mt = 4'd3; mo = 4'd4; bm = 4'b0000; slz = 1'b0;
    for (int k = 0; k < 2 * FRAME; k++) begin
      checks++;
      if ({num, an, fs, bp} !== model())
        $display("FAIL digits t=%0d got %h want %h", t, {num, an, fs, bp}, model());
      else passes++;
      tick();
    end
  endtask

  task automatic test_shadow();
    for (int k = 0; k < 2 * FRAME; k++) begin
      if (t % FRAME == SD) mo = 4'd7;
      checks++;
      if ({num, an, fs, bp} !== model())
        $display("FAIL shadow t=%0d got %h want %h", t, {num, an, fs, bp}, model());
      else passes++;
      tick();
    end
  endtask

  task automatic test_suppress();
    ht = 4'd0; slz = 1'b1;
    for (int k = 0; k < 4 * FRAME; k++) begin
      if (k == 2 * FRAME) slz = 1'b0;
      checks++;
      if ({num, an, fs, bp} !== model())
        $display("FAIL suppress t=%0d got %h want %h", t, {num, an, fs, bp}, model());
      else passes++;
      tick();
    end
  endtask

  task automatic test_blink();
    ht = 4'd1; bm = 4'b0011;
    for (int k = 0; k < 6 * FRAME; k++) begin
      checks++;
      if ({num, an, fs, bp} !== model())
        $display("FAIL blink t=%0d got %h want %h", t, {num, an, fs, bp}, model());
      else passes++;
      tick();
    end
  endtask

  task automatic test_hex();
    bm = 4'b0000; mo = 4'hC; ht = 4'hF; slz = 1'b1;
    for (int k = 0; k < 2 * FRAME; k++) begin
      checks++;
      if ({num, an, fs, bp} !== model())
        $display("FAIL hex t=%0d got %h want %h", t, {num, an, fs, bp}, model());
      else passes++;
      tick();
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 16 * FRAME; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        ht = 4'($urandom); ho = 4'($urandom); mt = 4'($urandom); mo = 4'($urandom);
        bm = 4'($urandom); slz = 1'($urandom);
        if ($urandom_range(0, 1) == 0) ht = 4'd0;
      end
      checks++;
      if ({num, an, fs, bp} !== model())
        $display("FAIL random t=%0d got %h want %h", t, {num, an, fs, bp}, model());
      else passes++;
      tick();
    end
  endtask

  task automatic test_reset_midslot();
    ht = 4'd5; ho = 4'd6; mt = 4'd7; mo = 4'd8; bm = 4'b1111; slz = 1'b0;
    while (!(((t / FRAME / BF) % 2 == 1) && t % FRAME == SD + 4 && t > 2 * FRAME)) tick();
    checks++;
    if (bp !== 1'b1 || an !== 4'hF || num !== 4'd6)
      $display("FAIL midslot_pre got %h/%h/%b want 6/f/1", num, an, bp);
    else passes++;
    bm = 4'b0000;
    #2 resetN = 1'b0;
    #1;
    checks++;
    if ({num, an, fs, bp} !== 10'b0000_1111_0_0)
      $display("FAIL midslot_async got %h want %h", {num, an, fs, bp}, 10'b0000_1111_0_0);
    else passes++;
    @(negedge clk);
    resetN = 1'b1;
    model_reset();
    #1;
    for (int k = 0; k < 2 * FRAME; k++) begin
      checks++;
      if ({num, an, fs, bp} !== model())
        $display("FAIL midslot_restart t=%0d got %h want %h", t, {num, an, fs, bp}, model());
      else passes++;
      tick();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_digits();
    test_shadow();
    test_suppress();
    test_blink();
    test_hex();
    test_random();
    test_reset_midslot();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/display_scan_mux.md
DISPLAY_SCAN_MUX -- requirements
Module: display_scan_mux

Interface
REQ-001 Parameter SCAN_DIV, default 1000, clock cycles per digit slot; SHALL be >= 2.
REQ-002 Parameter BLANK_CYCLES, default 16, anode-off guard cycles at the start of each slot; SHALL be < SCAN_DIV.
REQ-003 Parameter BLINK_FRAMES, default 64, complete scan frames per blink half-period; SHALL be >= 1.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 resetN  in  1  asynchronous, active-low reset.
REQ-006 hourTens, hourOnes, minTens, minOnes  in  4 each  BCD time digits.
REQ-007 blinkMask  in  4  per-digit blink enable; bit3=hourTens, bit0=minOnes.
REQ-008 suppressLeadingZero  in  1  blanks hourTens when its value is 0.
REQ-009 numberToDecode  out  4  nibble for the 7-segment decoder.
REQ-010 anodeN  out  4  active-low digit enables; bit3=hourTens, bit0=minOnes.
REQ-011 frameStart  out  1  one-cycle pulse at the first cycle of each new frame.
REQ-012 blinkPhase  out  1  current blink half-period; 1 = blinking digits dark.

Function
REQ-013 Cycle counter cnt SHALL count 0..SCAN_DIV-1 and wrap; slot index SHALL advance 0->1->2->3->0 on each cnt wrap.
REQ-014 Slot 0/1/2/3 SHALL select hourTens/hourOnes/minTens/minOnes and anodeN bit 3/2/1/0 respectively.
REQ-015 numberToDecode SHALL equal the shadow digit of the current slot for all SCAN_DIV cycles of that slot.
REQ-016 anodeN SHALL be 4'b1111 while cnt < BLANK_CYCLES; otherwise exactly the current slot's bit SHALL be 0, unless that digit is blanked.
REQ-017 Shadow registers (four digits, blinkMask, suppressLeadingZero) SHALL load from the inputs only on the edge where slot 3 wraps to slot 0; input changes at any other time SHALL NOT affect the current frame.
REQ-018 A digit SHALL be blanked (anodeN = 4'b1111 for its entire slot) if its shadow blinkMask bit = 1 and blinkPhase = 1.
REQ-019 hourTens SHALL be blanked if shadow suppressLeadingZero = 1 and shadow hourTens = 4'd0.
REQ-020 Digit values 10..15 SHALL be passed through unmodified and SHALL NOT be blanked.
REQ-021 The frame counter SHALL increment on each frame wrap; on the wrap where it equals BLINK_FRAMES-1 it SHALL clear to 0, and blinkPhase SHALL toggle on that same edge.
REQ-022 frameStart SHALL be 1 only in the cycle with slot = 0 and cnt = 0 that follows a frame wrap; it SHALL be 0 in the first cycle after reset release.
REQ-023 All outputs SHALL come from registers or from decode of registered state only; no input-to-output combinational path SHALL exist.

Reset
REQ-024 With resetN = 0, the following SHALL apply immediately, without a clock edge: cnt = 0, slot = 0, frame counter = 0, all shadow registers = 0, blinkPhase = 0, numberToDecode = 4'd0, anodeN = 4'b1111, frameStart = 0.
REQ-025 Reset asserted mid-slot SHALL abort the scan; after release, scanning SHALL restart at slot 0, cnt 0.
REQ-026 The first frame after reset SHALL display the zero shadow values: all digits 0, hourTens suppressed.

Verification (SCAN_DIV=8, BLANK_CYCLES=2, BLINK_FRAMES=2)
REQ-027 Drive resetN low between clock edges mid-slot -> anodeN = 1111, numberToDecode = 0, blinkPhase = 0 with no clock edge; release -> slot 0, cnt 0, frameStart = 0.
REQ-028 Drive digits 1,2,3,4 with suppress = 0 -> from the second frame: numberToDecode 1,2,3,4 for 8 cycles each; anodeN 1111 for 2 cycles, then 0111/1011/1101/1110 for 6 cycles; frameStart pulses every 32 cycles.
REQ-029 Change minOnes from 4 to 7 at slot 1 -> minOnes shows 4 for the rest of that frame and 7 from the next frameStart.
REQ-030 Drive hourTens = 0 with suppress = 1 -> anodeN = 1111 for all 8 cycles of slot 0; with suppress = 0 -> anodeN = 0111 for cycles 2..7.
REQ-031 Drive blinkMask = 0011 -> blinkPhase toggles every 64 cycles; minute anodes stay 1111 during phase 1 frames; hour anodes are unaffected.
REQ-032 Drive minOnes = 4'hC -> numberToDecode = 4'hC during slot 3, and anodeN = 1110 for cycles 2..7.
